// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: function encodings and controller states.
package alu_pkg;

  localparam logic [1:0] FUNC_ADD = 2'b00;
  localparam logic [1:0] FUNC_SUB = 2'b01;
  localparam logic [1:0] FUNC_MUL = 2'b10;
  localparam logic [1:0] FUNC_DIV = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module alu_div_step #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH:0]   part_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  assign q_bit_o = part_i >= {1'b0, divisor_i};
  // A zero divisor always "fits", which yields an all-ones quotient and remainder == dividend.
  assign rem_o   = q_bit_o ? (part_i[WIDTH-1:0] - divisor_i) : part_i[WIDTH-1:0];

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle add/sub, WIDTH-step shift-add multiply and restoring divide.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         func,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               ovf,
  output logic               dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [1:0]       func_q, func_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: mul partial product / div remainder (low half); sh: mul shifted multiplicand / divisor;
  // op: mul multiplier / div dividend shifting out while quotient bits shift in.
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    sh_q, sh_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [W2-1:0]    out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   div_part;
  logic [WIDTH-1:0] div_rem;
  logic             div_q;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign div_part = {acc_q[WIDTH-1:0], op_q[WIDTH-1]};

  alu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .part_i   (div_part),
    .divisor_i(sh_q[WIDTH-1:0]),
    .rem_o    (div_rem),
    .q_bit_o  (div_q)
  );

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    op_d    = op_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          func_d = func;
          cnt_d  = '0;
          unique case (func)
            FUNC_ADD: begin
              out_d   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              ovf_d   = sum[WIDTH];
              dbz_d   = 1'b0;
              state_d = StDone;
            end
            FUNC_SUB: begin
              out_d   = {{WIDTH{1'b0}}, a - b};
              ovf_d   = a < b;
              dbz_d   = 1'b0;
              state_d = StDone;
            end
            FUNC_MUL: begin
              acc_d   = '0;
              sh_d    = {{WIDTH{1'b0}}, a};
              op_d    = b;
              state_d = StBusy;
            end
            default: begin
              acc_d   = '0;
              sh_d    = {{WIDTH{1'b0}}, b};
              op_d    = a;
              state_d = StBusy;
            end
          endcase
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CW'(1);
        if (func_q == FUNC_MUL) begin
          acc_d = acc_q + (op_q[0] ? sh_q : '0);
          sh_d  = sh_q << 1;
          op_d  = op_q >> 1;
        end else begin
          acc_d = {{WIDTH{1'b0}}, div_rem};
          op_d  = {op_q[WIDTH-2:0], div_q};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StDone;
          out_d   = (func_q == FUNC_MUL) ? acc_d : {op_d, div_rem};
          ovf_d   = 1'b0;
          dbz_d   = (func_q == FUNC_DIV) && (sh_q[WIDTH-1:0] == '0);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      func_q  <= FUNC_ADD;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      op_q    <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter with a cycle-level reference model checked on every cycle.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     func = 2'b00;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] out;
  logic           ovf;
  logic           dbz;

  int n_cmp = 0;
  int n_bad = 0;

  alu_iter #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .func     (func),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result straight from arithmetic: {ovf, dbz, out}.
  function automatic logic [2*W+1:0] golden(input logic [1:0] f, input int x, input int y);
    int   lim;
    int   r;
    logic o;
    logic z;
    lim = 1 << W;
    o   = 1'b0;
    z   = 1'b0;
    case (f)
      FUNC_ADD: begin
        r = (x + y) % lim;
        o = (x + y) >= lim;
      end
      FUNC_SUB: begin
        r = (x - y + lim) % lim;
        o = x < y;
      end
      FUNC_MUL: r = x * y;
      default: begin
        if (y == 0) begin
          r = (lim - 1) * lim + x;
          z = 1'b1;
        end else begin
          r = (x / y) * lim + (x % y);
        end
      end
    endcase
    return {o, z, r[2*W-1:0]};
  endfunction

  // Transaction-level model: latency counter plus a pending result.
  int             m_wait = 0;
  logic           m_valid = 1'b0;
  logic [2*W-1:0] m_out = '0;
  logic           m_ovf = 1'b0;
  logic           m_dbz = 1'b0;
  logic [2*W+1:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait  <= 0;
      m_valid <= 1'b0;
      m_out   <= '0;
      m_ovf   <= 1'b0;
      m_dbz   <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid                <= 1'b1;
        {m_ovf, m_dbz, m_out}  <= m_pend;
      end
    end else if (in_valid) begin
      if (func == FUNC_ADD || func == FUNC_SUB) begin
        m_valid               <= 1'b1;
        {m_ovf, m_dbz, m_out} <= golden(func, int'(a), int'(b));
      end else begin
        m_pend <= golden(func, int'(a), int'(b));
        m_wait <= W;
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 0) begin
      chk("model in_ready", in_ready, !m_valid && (m_wait == 0));
      chk("model out_valid", out_valid, m_valid);
      chk("model out", out, m_out);
      chk("model ovf", ovf, m_ovf);
      chk("model dbz", dbz, m_dbz);
    end
  end

  task automatic run_cmd(input string nm, input logic [1:0] f, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v, input int hold, input logic [2*W-1:0] exp_out,
                         input logic exp_ovf, input logic exp_dbz, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({nm, " ready before"}, in_ready, 1);
    in_valid  = 1'b1;
    func      = f;
    a         = ta;
    b         = tb_v;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    func     = 2'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
    lat      = 1;
    while (!out_valid && lat < 50) begin
      chk({nm, " ready busy"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " out"}, out, exp_out);
    chk({nm, " ovf"}, ovf, exp_ovf);
    chk({nm, " dbz"}, dbz, exp_dbz);
    for (int i = 0; i < hold; i++) begin
      chk({nm, " hold valid"}, out_valid, 1);
      chk({nm, " hold out"}, out, exp_out);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk({nm, " consume ready"}, in_ready, 0);
    chk({nm, " consume valid"}, out_valid, 1);
    @(negedge clk);
    chk({nm, " after ready"}, in_ready, 1);
    chk({nm, " after valid"}, out_valid, 0);
  endtask

  initial begin
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out", out, 0);
    chk("reset ovf", ovf, 0);
    chk("reset dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmd("add 63+1", FUNC_ADD, 6'd63, 6'd1, 0, 12'h000, 1'b1, 1'b0, 1);
    run_cmd("sub 5-9", FUNC_SUB, 6'd5, 6'd9, 0, 12'h03C, 1'b1, 1'b0, 1);
    run_cmd("mul 63*63", FUNC_MUL, 6'd63, 6'd63, 0, 12'hF81, 1'b0, 1'b0, W + 1);
    run_cmd("div 45/7", FUNC_DIV, 6'd45, 6'd7, 0, 12'h183, 1'b0, 1'b0, W + 1);
    run_cmd("div 13/0", FUNC_DIV, 6'd13, 6'd0, 0, 12'hFCD, 1'b0, 1'b1, W + 1);
    run_cmd("mul 2*3 hold", FUNC_MUL, 6'd2, 6'd3, 3, 12'h006, 1'b0, 1'b0, W + 1);
    run_cmd("add 10+20", FUNC_ADD, 6'd10, 6'd20, 0, 12'h01E, 1'b0, 1'b0, 1);
    run_cmd("sub 9-5", FUNC_SUB, 6'd9, 6'd5, 2, 12'h004, 1'b0, 1'b0, 1);
    run_cmd("mul 37*0", FUNC_MUL, 6'd37, 6'd0, 0, 12'h000, 1'b0, 1'b0, W + 1);
    run_cmd("div 63/1", FUNC_DIV, 6'd63, 6'd1, 0, 12'hFC0, 1'b0, 1'b0, W + 1);
    run_cmd("div 5/9", FUNC_DIV, 6'd5, 6'd9, 0, 12'h005, 1'b0, 1'b0, W + 1);

    // Abort a divide mid-flight with reset.
    @(negedge clk);
    in_valid  = 1'b1;
    func      = FUNC_DIV;
    a         = 6'd45;
    b         = 6'd7;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort out", out, 0);
    chk("abort in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk("abort no result", out_valid, 0);
    end
    run_cmd("add 1+1", FUNC_ADD, 6'd1, 6'd1, 0, 12'h002, 1'b0, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, command valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a command.
REQ-006 SHALL have port a, input, WIDTH, first unsigned operand.
REQ-007 SHALL have port b, input, WIDTH, second unsigned operand.
REQ-008 SHALL have port func, input, 2, operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port out, output, 2*WIDTH, result.
REQ-012 SHALL have port ovf, output, 1, add carry-out or sub borrow; 0 for mul/div.
REQ-013 SHALL have port dbz, output, 1, divide-by-zero; 0 for add/sub/mul.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept when in_valid && in_ready, capturing a, b, func; later input changes are ignored.
REQ-016 SHALL, for add/sub, go IDLE->DONE; out_valid high in cycle T+1 after the accept cycle T.
REQ-017 SHALL, for mul/div, go IDLE->BUSY, perform exactly WIDTH iteration steps (one bit per cycle), then go to DONE; out_valid high in cycle T+WIDTH+1.
REQ-018 SHALL compute add as out = {WIDTH zeros, (a+b) mod 2^WIDTH}, ovf = carry-out.
REQ-019 SHALL compute sub as out = {WIDTH zeros, (a-b) mod 2^WIDTH}, ovf = 1 if a < b.
REQ-020 SHALL compute mul as out = full 2*WIDTH unsigned product, via shift-add.
REQ-021 SHALL compute div via restoring division as out[2W-1:W] = a/b, out[W-1:0] = a%b.
REQ-022 SHALL, on div with b=0, still take WIDTH+1 cycles and return quotient all ones, remainder = a, dbz=1.
REQ-023 SHALL hold out, ovf, dbz, out_valid stable in DONE until out_ready=1; DONE->IDLE on out_valid && out_ready.
REQ-024 SHALL NOT accept a new command in the cycle a result is consumed; in_ready rises the following cycle.
REQ-025 SHALL keep out, ovf, dbz at their last values outside DONE; only out_valid qualifies them.

Reset
REQ-026 SHALL, on rst_n low, immediately force IDLE, out_valid=0, out=0, ovf=0, dbz=0, clear iteration counter and working registers.
REQ-027 SHALL abandon any in-progress BUSY or DONE operation on reset with no result emitted; in_ready=1 while rst_n low and after release.

Structure
REQ-028 SHALL take func encodings (FUNC_ADD/SUB/MUL/DIV) and FSM state enum from shared package alu_pkg.
REQ-029 SHALL place one combinational restoring-division step (partial remainder, divisor -> next remainder, quotient bit) in sub-module alu_div_step; multiply step stays inline.
REQ-030 SHALL size the iteration counter as $clog2(WIDTH+1) bits.

Verification (WIDTH=6)
REQ-031 add a=63 b=1, out_ready=1 -> at T+1 out=0x000, ovf=1, dbz=0.
REQ-032 sub a=5 b=9 -> at T+1 out=0x03C, ovf=1.
REQ-033 mul a=63 b=63 -> out_valid first at T+7, out=0xF81, ovf=0; in_ready=0 during T+1..T+7.
REQ-034 div a=45 b=7 -> out=0x183 (q=6, r=3), dbz=0; div a=13 b=0 -> out=0xFCD, dbz=1, both at T+7.
REQ-035 mul 2x3 with out_ready=0 for 3 cycles after out_valid -> out=0x006 stable throughout; in_ready=0 in consume cycle, 1 next cycle.
REQ-036 div 45/7, rst_n low at T+3 -> out_valid=0, out=0 immediately; after release no result appears and next add 1+1 returns 0x002 at T'+1.
